// File: rtl/spi_flash_responder.sv
// SPI flash slave emulating a tiny NOR array (WREN/WRDI/RDSR/READ/PP/SE).
// SPI pins are oversampled on clk; no logic runs in the dclk domain.
module spi_flash_responder #(
    parameter int ADDR_W  = 8,
    parameter int PP_BUSY = 16,
    parameter int SE_BUSY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic ncs,
    input  logic dclk,
    input  logic w_pin,
    output logic r_pin,
    output logic wip,
    output logic wel
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_RDATA  = 3'd3;
    localparam logic [2:0] S_STAT   = 3'd4;
    localparam logic [2:0] S_WDATA  = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_PP   = 2'd1;
    localparam logic [1:0] OP_SE   = 2'd2;

    logic [1:0] ncs_s, dclk_s, w_s;
    logic       ncs_d, dclk_d;
    logic       rise, fall, cs_fall, cs_rise;

    logic [2:0]        state;
    logic [1:0]        op;
    logic [7:0]        sh, sh_next;
    logic [2:0]        bit_idx, rcnt;
    logic [5:0]        nbits;
    logic [ADDR_W-1:0] addr, addr_next, addr_inc;
    logic [7:0]        out_sh;
    logic              prog_en, programmed;
    logic              erasing;
    logic [ADDR_W-1:0] erase_addr;
    logic [15:0]       busy_cnt;
    logic [7:0]        stat;

    logic [7:0]        mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [7:0]        mem_wd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ncs_s  <= 2'b11;
            dclk_s <= 2'b00;
            w_s    <= 2'b00;
            ncs_d  <= 1'b1;
            dclk_d <= 1'b0;
        end else begin
            ncs_s  <= {ncs_s[0], ncs};
            dclk_s <= {dclk_s[0], dclk};
            w_s    <= {w_s[0], w_pin};
            ncs_d  <= ncs_s[1];
            dclk_d <= dclk_s[1];
        end
    end

    assign rise      = dclk_s[1] & ~dclk_d;
    assign fall      = ~dclk_s[1] & dclk_d;
    assign cs_fall   = ~ncs_s[1] & ncs_d;
    assign cs_rise   = ncs_s[1] & ~ncs_d;
    assign sh_next   = {sh[6:0], w_s[1]};
    assign addr_next = {addr[ADDR_W-2:0], w_s[1]};
    assign addr_inc  = addr + ADDR_W'(1);
    assign stat      = {6'b0, wel, wip};

    // Single write port: PP is refused while busy, so it never meets the erase walk.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = erase_addr;
        mem_wd = 8'hFF;
        if (erasing) begin
            mem_we = 1'b1;
        end else if (rise && state == S_WDATA && bit_idx == 3'd7 && prog_en) begin
            mem_we = 1'b1;
            mem_wa = addr;
            mem_wd = mem[addr] & sh_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            op         <= OP_READ;
            sh         <= 8'h00;
            bit_idx    <= 3'd0;
            rcnt       <= 3'd0;
            nbits      <= 6'd0;
            addr       <= '0;
            out_sh     <= 8'h00;
            prog_en    <= 1'b0;
            programmed <= 1'b0;
            r_pin      <= 1'b0;
            wel        <= 1'b0;
            wip        <= 1'b0;
            erasing    <= 1'b0;
            erase_addr <= '0;
            busy_cnt   <= 16'd0;
        end else begin
            if (state != S_RDATA && state != S_STAT) r_pin <= 1'b0;

            if (erasing) begin
                erase_addr <= erase_addr + ADDR_W'(1);
                if (erase_addr == '1) begin
                    erasing  <= 1'b0;
                    busy_cnt <= 16'(SE_BUSY - 1);
                end
            end else if (wip) begin
                if (busy_cnt == 16'd0) wip <= 1'b0;
                else busy_cnt <= busy_cnt - 16'd1;
            end

            if (cs_fall) begin
                state      <= S_CMD;
                bit_idx    <= 3'd0;
                nbits      <= 6'd0;
                prog_en    <= 1'b0;
                programmed <= 1'b0;
            end else if (cs_rise) begin
                state <= S_IDLE;
                r_pin <= 1'b0;
                if (state == S_ADDR && op == OP_SE && nbits == 6'd32 && wel) begin
                    wip        <= 1'b1;
                    wel        <= 1'b0;
                    erasing    <= 1'b1;
                    erase_addr <= '0;
                end else if (state == S_WDATA && programmed) begin
                    wip      <= 1'b1;
                    wel      <= 1'b0;
                    busy_cnt <= 16'(PP_BUSY - 1);
                end
            end else if (rise) begin
                sh      <= sh_next;
                bit_idx <= bit_idx + 3'd1;
                if (nbits != 6'h3F) nbits <= nbits + 6'd1;
                case (state)
                    S_CMD: begin
                        if (bit_idx == 3'd7) begin
                            if (wip && sh_next != 8'h05) begin
                                state <= S_IGNORE;
                            end else begin
                                unique case (sh_next)
                                    8'h06: begin
                                        wel   <= 1'b1;
                                        state <= S_IGNORE;
                                    end
                                    8'h04: begin
                                        wel   <= 1'b0;
                                        state <= S_IGNORE;
                                    end
                                    8'h05: begin
                                        state <= S_STAT;
                                        rcnt  <= 3'd0;
                                    end
                                    8'h03: begin
                                        state <= S_ADDR;
                                        op    <= OP_READ;
                                    end
                                    8'h02: begin
                                        state   <= S_ADDR;
                                        op      <= OP_PP;
                                        prog_en <= wel;
                                    end
                                    8'hD8: begin
                                        state <= S_ADDR;
                                        op    <= OP_SE;
                                    end
                                    default: state <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        addr <= addr_next;
                        // 32nd bit overall closes the 24-bit address
                        if (nbits == 6'd31 && op != OP_SE) begin
                            state  <= (op == OP_READ) ? S_RDATA : S_WDATA;
                            out_sh <= mem[addr_next];
                            rcnt   <= 3'd0;
                        end
                    end
                    S_WDATA: begin
                        if (bit_idx == 3'd7) begin
                            if (prog_en) programmed <= 1'b1;
                            addr <= addr_inc;
                        end
                    end
                    default: ;
                endcase
            end else if (fall) begin
                case (state)
                    S_RDATA: begin
                        r_pin <= out_sh[7];
                        rcnt  <= rcnt + 3'd1;
                        if (rcnt == 3'd7) begin
                            addr   <= addr_inc;
                            out_sh <= mem[addr_inc];
                        end else begin
                            out_sh <= {out_sh[6:0], 1'b0};
                        end
                    end
                    S_STAT: begin
                        r_pin <= stat[3'd7 - rcnt];
                        rcnt  <= rcnt + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
